// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial WIDTH-bit adder sequencer driving one shared fullAdder cell, LSB first
// Optional build macro SERIAL_ADD_SUB_EN adds a sub input for two's-complement subtraction.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             c_in,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  assign last_bit = (cnt == LAST);

  // Subtraction is a + ~b + 1, so only the loaded operand and seed carry differ.
  always_comb begin
`ifdef SERIAL_ADD_SUB_EN
    b_load     = sub ? ~op_b : op_b;
    carry_load = sub ? 1'b1 : c_in;
`else
    b_load     = op_b;
    carry_load = c_in;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    fa_a   = 1'b0;
    fa_b   = 1'b0;
    fa_cin = 1'b0;
    case (state)
      RUN: begin
        busy   = 1'b1;
        fa_a   = a_sr[0];
        fa_b   = b_sr[0];
        fa_cin = carry_q;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // result is not cleared on start; WIDTH shifts fully overwrite it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      result  <= '0;
      c_out   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr    <= op_a;
            b_sr    <= b_load;
            carry_q <= carry_load;
            cnt     <= '0;
          end
        end
        RUN: begin
          result  <= {fa_sum, result[WIDTH-1:1]};
          a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
          carry_q <= fa_cout;
          cnt     <= cnt + CNT_W'(1);
          if (last_bit) c_out <= fa_cout;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - randomized self-checking bench for serial_add_ctrl against an arithmetic model
// Define SERIAL_ADD_SUB_EN to also exercise the subtract build.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         c_in = 1'b0;
  logic         sub = 1'b0;
  logic         busy, done, c_out;
  logic [W-1:0] result;
  logic         fa_a, fa_b, fa_cin, fa_sum, fa_cout;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .c_in    (c_in),
`ifdef SERIAL_ADD_SUB_EN
    .sub     (sub),
`endif
    .busy    (busy),
    .done    (done),
    .result  (result),
    .c_out   (c_out),
    .fa_a    (fa_a),
    .fa_b    (fa_b),
    .fa_cin  (fa_cin),
    .fa_sum  (fa_sum),
    .fa_cout (fa_cout)
  );

  // The shared external full-adder cell.
  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_fa_idle(input string tag);
    check({tag, "_fa"}, {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
  endtask

  // One full operation from IDLE; optionally pulses a stray start in RUN cycle 3.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       input logic s, input bit noise);
    logic [W-1:0] bb;
    logic         cc;
    logic [W:0]   exp;
    int           n, mask, cin_k;
    bb  = s ? ~b : b;
    cc  = s ? 1'b1 : ci;
    exp = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cc};
    op_a = a; op_b = b; c_in = ci; sub = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op_a = W'($urandom); op_b = W'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
    n = 0;
    while (!done && n < 4 * W) begin
      check("run_busy", {31'd0, busy}, 32'd1);
      if (n < W) begin
        mask  = (1 << n) - 1;
        cin_k = ((int'(a) & mask) + (int'(bb) & mask) + int'(cc)) >> n;
        check("fa_a", {31'd0, fa_a}, 32'((int'(a) >> n) & 1));
        check("fa_b", {31'd0, fa_b}, 32'((int'(bb) >> n) & 1));
        check("fa_cin", {31'd0, fa_cin}, 32'(cin_k & 1));
      end
      if (noise && n == 2) begin
        start = 1'b1; op_a = W'($urandom); op_b = W'($urandom); c_in = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check("latency", 32'(n + 1), 32'(W + 1));
    check("result", {24'd0, result}, {24'd0, exp[W-1:0]});
    check("c_out", {31'd0, c_out}, {31'd0, exp[W]});
    check("done_busy", {31'd0, busy}, 32'd1);
    check_fa_idle("done");
    @(posedge clk); #1;
    check("done_once", {31'd0, done}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("result_held", {23'd0, c_out, result}, {23'd0, exp});
    check_fa_idle("idle");
  endtask

  initial begin
    int cyc, last_done, ndone, guard;
    #1;
    check("rst_outs", {26'd0, busy, done, c_out, fa_a, fa_b, fa_cin}, 32'd0);
    check("rst_result", {24'd0, result}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    do_op(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);
    do_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);

    // start held high: a new op every W+2 cycles.
    op_a = 8'h01; op_b = 8'h01; c_in = 1'b0; sub = 1'b0; start = 1'b1;
    last_done = 0; ndone = 0;
    for (cyc = 1; cyc <= 36; cyc++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (last_done == 0) check("b2b_first", 32'(cyc), 32'(W + 1));
        else check("b2b_period", 32'(cyc - last_done), 32'(W + 2));
        check("b2b_result", {23'd0, c_out, result}, 32'h002);
        last_done = cyc;
      end
      if (!busy || done) check_fa_idle("b2b");
    end
    start = 1'b0;
    check("b2b_count", 32'(ndone), 32'd3);
    guard = 0;
    while (busy && guard < 4 * W) begin
      @(posedge clk); #1;
      guard++;
    end
    check("b2b_drain", {31'd0, busy}, 32'd0);

    // Reset in RUN cycle 4 aborts without a done pulse.
    op_a = 8'hAA; op_b = 8'h55; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_outs", {26'd0, busy, done, c_out, fa_a, fa_b, fa_cin}, 32'd0);
    check("abort_result", {24'd0, result}, 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_nodone", {31'd0, done}, 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'($urandom));
    end

`ifdef SERIAL_ADD_SUB_EN
    do_op(8'h10, 8'h01, 1'b0, 1'b1, 1'b0);
    do_op(8'h01, 8'h02, 1'b1, 1'b1, 1'b0);
    do_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
